// File: rtl/link_pkg.sv
// Framing constants and FSM encodings shared by the score link hub and its RX assemblers.
// Build option LINK_CHECKSUM_EN: frames carry a trailing XOR checksum byte (6 bytes instead of 5).
package link_pkg;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam int         PAYLOAD_BYTES = 4;
`ifdef LINK_CHECKSUM_EN
   localparam int         FRAME_BYTES   = PAYLOAD_BYTES + 2;
`else
   localparam int         FRAME_BYTES   = PAYLOAD_BYTES + 1;
`endif

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_SNAP,
      TX_SEND,
      TX_WAIT_HI,
      TX_WAIT_LO,
      TX_NEXT_CH
   } tx_state_t;

   typedef enum logic {
      RX_HUNT,
      RX_COLLECT
   } rx_state_t;

   // Byte idx of the outgoing frame for a {id, points} snapshot; idx 5 is the checksum.
   function automatic logic [7:0] frame_byte(input logic [31:0] snap, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = snap[31:24];
         3'd2:    b = snap[23:16];
         3'd3:    b = snap[15:8];
         3'd4:    b = snap[7:0];
         default: b = snap[31:24] ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/link_rx_assembler.sv
// One-channel frame assembler: hunts for SYNC, shifts in the payload, publishes or drops the frame.
// Build option LINK_CHECKSUM_EN: a fifth byte after SYNC is checked against the payload XOR.
module link_rx_assembler
   import link_pkg::*;
#(
   parameter int TIMEOUT_CYC = 150000
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic [31:0] ext_data_o,
   output logic        ext_valid_o,
   output logic        frame_err_o
);

   localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam int              RX_BYTES = FRAME_BYTES - 1;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0] TO_SAT   = TO_W'(TIMEOUT_CYC);

   rx_state_t       state_q;
   logic [2:0]      cnt_q;
   logic [TO_W-1:0] to_q;
   logic [31:0]     shift_q;
   logic [31:0]     ext_q;
   logic            valid_q;
   logic            err_q;
`ifdef LINK_CHECKSUM_EN
   logic [7:0]      chk_q;
`endif

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state_q <= RX_HUNT;
         cnt_q   <= '0;
         to_q    <= '0;
         ext_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef LINK_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            RX_HUNT: begin
               if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
                  state_q <= RX_COLLECT;
                  cnt_q   <= '0;
                  to_q    <= '0;
`ifdef LINK_CHECKSUM_EN
                  chk_q   <= '0;
`endif
               end
            end
            RX_COLLECT: begin
               // SYNC values inside a frame are ordinary payload; there is no resync.
               if (rx_valid_i) begin
                  to_q  <= '0;
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q < 3'(PAYLOAD_BYTES))
                     shift_q <= {shift_q[23:0], rx_data_i};
`ifdef LINK_CHECKSUM_EN
                  chk_q <= chk_q ^ rx_data_i;
                  if (cnt_q == 3'(RX_BYTES - 1)) begin
                     state_q <= RX_HUNT;
                     if (rx_data_i == chk_q) begin
                        ext_q   <= shift_q;
                        valid_q <= 1'b1;
                     end else begin
                        err_q   <= 1'b1;
                     end
                  end
`else
                  if (cnt_q == 3'(RX_BYTES - 1)) begin
                     state_q <= RX_HUNT;
                     ext_q   <= {shift_q[23:0], rx_data_i};
                     valid_q <= 1'b1;
                  end
`endif
               end else if (to_q == TO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= RX_HUNT;
               end else if (to_q != TO_SAT) begin
                  to_q <= to_q + TO_W'(1);
               end
            end
            default: state_q <= RX_HUNT;
         endcase
      end
   end

   assign ext_data_o  = ext_q;
   assign ext_valid_o = valid_q;
   assign frame_err_o = err_q;

endmodule

// File: rtl/score_link_hub.sv
// Score link hub: broadcasts the local {id, points} frame round-robin on N_CH UART links and
// assembles incoming frames per link. Build option LINK_CHECKSUM_EN adds a checksum byte.
module score_link_hub
   import link_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int GAP_CYC     = 75000,
   parameter int TIMEOUT_CYC = 150000
) (
   input  logic                pclk,
   input  logic                rst,
   input  logic [7:0]          local_id,
   input  logic [23:0]         points,
   input  logic [N_CH-1:0]     tx_busy,
   output logic [N_CH-1:0]     tx_start,
   output logic [7:0]          tx_data,
   input  logic [N_CH-1:0]     rx_valid,
   input  logic [8*N_CH-1:0]   rx_data,
   output logic [32*N_CH-1:0]  ext_data,
   output logic [N_CH-1:0]     ext_valid,
   output logic [N_CH-1:0]     frame_err
);

   localparam int               GAP_W    = $clog2(GAP_CYC + 1);
   localparam int               CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   tx_state_t        state_q;
   logic [GAP_W-1:0] gap_q;
   logic [CH_W-1:0]  ch_q;
   logic [2:0]       idx_q;
   logic [1:0]       hi_q;
   logic [31:0]      snap_q;
   logic [N_CH-1:0]  start_q;
   logic [7:0]       data_q;
   logic             busy_sel;

   assign busy_sel = tx_busy[ch_q];

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state_q <= TX_IDLE;
         gap_q   <= '0;
         ch_q    <= '0;
         idx_q   <= '0;
         hi_q    <= '0;
         start_q <= '0;
         data_q  <= '0;
      end else begin
         start_q <= '0;
         case (state_q)
            TX_IDLE: begin
               if (gap_q == GAP_LAST) begin
                  gap_q   <= '0;
                  state_q <= TX_SNAP;
               end else begin
                  gap_q <= gap_q + GAP_W'(1);
               end
            end
            TX_SNAP: begin
               snap_q  <= {local_id, points};
               ch_q    <= '0;
               idx_q   <= '0;
               state_q <= TX_SEND;
            end
            TX_SEND: begin
               if (!busy_sel) begin
                  start_q[ch_q] <= 1'b1;
                  data_q        <= frame_byte(snap_q, idx_q);
                  hi_q          <= '0;
                  state_q       <= TX_WAIT_HI;
               end
            end
            TX_WAIT_HI: begin
               // A transmitter that never raises busy is released after four cycles.
               if (busy_sel || hi_q == 2'd3) state_q <= TX_WAIT_LO;
               else                          hi_q    <= hi_q + 2'd1;
            end
            TX_WAIT_LO: begin
               if (!busy_sel) begin
                  if (idx_q == 3'(FRAME_BYTES - 1)) begin
                     state_q <= TX_NEXT_CH;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     state_q <= TX_SEND;
                  end
               end
            end
            TX_NEXT_CH: begin
               idx_q <= '0;
               if (ch_q == CH_W'(N_CH - 1)) begin
                  state_q <= TX_IDLE;
               end else begin
                  ch_q    <= ch_q + CH_W'(1);
                  state_q <= TX_SEND;
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx_start = start_q;
   assign tx_data  = data_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_rx
      link_rx_assembler #(
         .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_rx (
         .pclk        (pclk),
         .rst         (rst),
         .rx_valid_i  (rx_valid[k]),
         .rx_data_i   (rx_data[8*k +: 8]),
         .ext_data_o  (ext_data[32*k +: 32]),
         .ext_valid_o (ext_valid[k]),
         .frame_err_o (frame_err[k])
      );
   end

endmodule

// File: tb/tb_score_link_hub.sv
// Self-checking bench for score_link_hub: TX rounds against a byte-level frame model, RX vector
// table plus randomized frames against a stream-parsing reference model, timeout and reset cases.
module tb_score_link_hub;
   import link_pkg::*;

   localparam int N_CH        = 2;
   localparam int GAP_CYC     = 20;
   localparam int TIMEOUT_CYC = 30;
   localparam int FB          = FRAME_BYTES;
`ifdef LINK_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic                pclk = 1'b0;
   logic                rst = 1'b0;
   logic [7:0]          local_id = 8'h00;
   logic [23:0]         points = 24'h0;
   logic [N_CH-1:0]     tx_busy = '0;
   logic [N_CH-1:0]     tx_start;
   logic [7:0]          tx_data;
   logic [N_CH-1:0]     rx_valid = '0;
   logic [8*N_CH-1:0]   rx_data = '0;
   logic [32*N_CH-1:0]  ext_data;
   logic [N_CH-1:0]     ext_valid;
   logic [N_CH-1:0]     frame_err;

   int          nchk = 0;
   int          nerr = 0;
   int          start_viol = 0;
   int          busy_cnt [N_CH];
   int          ev_cnt [N_CH];
   int          er_cnt [N_CH];
   logic [15:0] txlog [$];
   logic [31:0] exp_ext [N_CH];

   typedef struct {
      int          ch;
      int          n;
      logic [63:0] b;
      bit          upd;
      bit          err;
      logic [31:0] data;
   } rxvec_t;
   rxvec_t tbl [5];

   always #5 pclk = ~pclk;

   score_link_hub #(
      .N_CH        (N_CH),
      .GAP_CYC     (GAP_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .pclk      (pclk),
      .rst       (rst),
      .local_id  (local_id),
      .points    (points),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .ext_data  (ext_data),
      .ext_valid (ext_valid),
      .frame_err (frame_err)
   );

   // Transmitter model (busy for 10 cycles per byte), TX byte logger and RX pulse counters.
   always @(negedge pclk) begin
      for (int k = 0; k < N_CH; k++) begin
         ev_cnt[k] += int'(ext_valid[k]);
         er_cnt[k] += int'(frame_err[k]);
         if (tx_start[k]) begin
            if (tx_busy[k]) start_viol++;
            txlog.push_back({8'(k), tx_data});
            busy_cnt[k] = 10;
         end else if (busy_cnt[k] > 0) begin
            busy_cnt[k]--;
         end
         tx_busy[k] = (busy_cnt[k] > 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      nchk++;
      nerr++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   function automatic logic [7:0] exp_byte(input logic [7:0] id, input logic [23:0] p, input int i);
      logic [7:0] f [6];
      f[0] = 8'hA5;
      f[1] = id;
      f[2] = p[23:16];
      f[3] = p[15:8];
      f[4] = p[7:0];
      f[5] = id ^ p[23:16] ^ p[15:8] ^ p[7:0];
      return f[i];
   endfunction

   function automatic logic [127:0] mk_frame(input logic [7:0] id, input logic [23:0] p, input bit bad);
      logic [127:0] s = '0;
      for (int i = 0; i < FB; i++) s[8*i +: 8] = exp_byte(id, p, i);
      if (bad) s[8*(FB-1) +: 8] = s[8*(FB-1) +: 8] ^ 8'h01;
      return s;
   endfunction

   // Reference parser: skip to the first SYNC, take the payload (and checksum) that follows it.
   task automatic rx_model(input logic [127:0] s, input int n, output bit upd, output bit err,
                           output logic [31:0] d);
      int i = 0;
      logic [7:0] x;
      upd = 1'b0;
      err = 1'b0;
      d   = '0;
      while (i < n && s[8*i +: 8] != 8'hA5) i++;
      i++;
      if (n - i < 4 + int'(CS)) return;
      d = {s[8*i +: 8], s[8*(i+1) +: 8], s[8*(i+2) +: 8], s[8*(i+3) +: 8]};
      if (CS) begin
         x   = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
         err = (s[8*(i+4) +: 8] != x);
      end
      upd = !err;
   endtask

   task automatic drive(input logic [127:0] s0, input int n0, input logic [127:0] s1, input int n1);
      int n = (n0 > n1) ? n0 : n1;
      for (int t = 0; t < n; t++) begin
         rx_valid[0]   = (t < n0);
         rx_data[7:0]  = s0[8*t +: 8];
         rx_valid[1]   = (t < n1);
         rx_data[15:8] = s1[8*t +: 8];
         @(negedge pclk);
      end
      rx_valid = '0;
   endtask

   task automatic wait_log(input int n, input string name);
      int w = 0;
      while (txlog.size() < n && w < 4000) begin
         @(negedge pclk);
         w++;
      end
      if (txlog.size() < n) fail_timeout(name);
   endtask

   task automatic check_round(input logic [7:0] id, input logic [23:0] p, input string name);
      logic [15:0] e;
      wait_log(2*FB, name);
      if (txlog.size() < 2*FB) return;
      for (int j = 0; j < 2*FB; j++) begin
         e = {8'(j / FB), exp_byte(id, p, j % FB)};
         chk(name, 64'(txlog.pop_front()), 64'(e));
      end
   endtask

   task automatic check_rx_all(input int ev0 [N_CH], input int er0 [N_CH], input bit upd [N_CH],
                               input bit err [N_CH], input string name);
      for (int k = 0; k < N_CH; k++) begin
         chk({name, "_valid"}, 64'(ev_cnt[k] - ev0[k]), 64'(upd[k]));
         chk({name, "_err"}, 64'(er_cnt[k] - er0[k]), 64'(err[k]));
         chk({name, "_data"}, 64'(ext_data[32*k +: 32]), 64'(exp_ext[k]));
      end
   endtask

   initial begin
      int          ev0 [N_CH];
      int          er0 [N_CH];
      bit          upd [N_CH];
      bit          err [N_CH];
      logic [127:0] s [N_CH];
      int          n [N_CH];
      logic [31:0] d;
      logic [7:0]  id;
      logic [23:0] p;
      int          cnt;
      int          pre;

      for (int k = 0; k < N_CH; k++) exp_ext[k] = '0;
`ifdef LINK_CHECKSUM_EN
      tbl[0] = '{1, 7, 64'h11A50700998816, 1'b1, 1'b0, 32'h07009988};
      tbl[1] = '{0, 6, 64'hA50301234564,   1'b1, 1'b0, 32'h03012345};
      tbl[2] = '{0, 6, 64'hA50301234565,   1'b0, 1'b1, 32'h03012345};
      tbl[3] = '{0, 6, 64'hA5A5123456D5,   1'b1, 1'b0, 32'hA5123456};
      tbl[4] = '{1, 3, 64'h112233,         1'b0, 1'b0, 32'h07009988};
`else
      tbl[0] = '{1, 6, 64'h11A507009988,   1'b1, 1'b0, 32'h07009988};
      tbl[1] = '{0, 5, 64'hA503012345,     1'b1, 1'b0, 32'h03012345};
      tbl[2] = '{0, 5, 64'hA5A5123456,     1'b1, 1'b0, 32'hA5123456};
      tbl[3] = '{1, 7, 64'h00FFA5DEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[4] = '{0, 3, 64'h112233,         1'b0, 1'b0, 32'hA5123456};
`endif

      // Reset state
      local_id = 8'h03;
      points   = 24'h012345;
      repeat (3) @(negedge pclk);
      chk("rst_tx_start", 64'(tx_start), 64'h0);
      chk("rst_tx_data", 64'(tx_data), 64'h0);
      chk("rst_ext_data", 64'(ext_data), 64'h0);
      chk("rst_ext_valid", 64'(ext_valid), 64'h0);
      chk("rst_frame_err", 64'(frame_err), 64'h0);

      // First broadcast follows the reset gap
      rst = 1'b1;
      cnt = 0;
      while (tx_start == '0 && cnt < 200) begin
         @(negedge pclk);
         cnt++;
      end
      nchk++;
      if (cnt < GAP_CYC || cnt > GAP_CYC + 3) begin
         nerr++;
         $display("FAIL first_start_latency: got %0d cycles expected %0d..%0d", cnt, GAP_CYC, GAP_CYC + 3);
      end
      check_round(8'h03, 24'h012345, "tx_round_basic");

      // Snapshot must survive input changes during the round
      points = 24'h000001;
      wait_log(2, "tx_snap_wait");
      points = 24'h000002;
      check_round(8'h03, 24'h000001, "tx_snapshot_hold");

      for (int r = 0; r < 3; r++) begin
         id       = 8'($urandom);
         p        = 24'($urandom);
         local_id = id;
         points   = p;
         wait_log($urandom_range(1, 2*FB - 1), "tx_rand_wait");
         local_id = 8'($urandom);
         points   = 24'($urandom);
         check_round(id, p, "tx_round_rand");
      end
      chk("no_start_while_busy", 64'(start_viol), 64'h0);

      // RX vector table
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < N_CH; k++) begin
            ev0[k] = ev_cnt[k];
            er0[k] = er_cnt[k];
            upd[k] = 1'b0;
            err[k] = 1'b0;
            s[k]   = '0;
            n[k]   = 0;
         end
         for (int j = 0; j < tbl[i].n; j++)
            s[tbl[i].ch][8*j +: 8] = tbl[i].b[8*(tbl[i].n - 1 - j) +: 8];
         n[tbl[i].ch]   = tbl[i].n;
         upd[tbl[i].ch] = tbl[i].upd;
         err[tbl[i].ch] = tbl[i].err;
         exp_ext[tbl[i].ch] = tbl[i].data;
         drive(s[0], n[0], s[1], n[1]);
         repeat (4) @(negedge pclk);
         check_rx_all(ev0, er0, upd, err, "rx_vec");
      end

      // Inter-byte timeout inside a frame, then recovery
      ev0[0] = ev_cnt[0];
      er0[0] = er_cnt[0];
      drive(128'h07A5, 2, 128'h0, 0);
      repeat (TIMEOUT_CYC - 2) @(negedge pclk);
      chk("timeout_not_early", 64'(er_cnt[0] - er0[0]), 64'h0);
      repeat (6) @(negedge pclk);
      chk("timeout_err", 64'(er_cnt[0] - er0[0]), 64'h1);
      chk("timeout_no_valid", 64'(ev_cnt[0] - ev0[0]), 64'h0);
      chk("timeout_data_held", 64'(ext_data[31:0]), 64'(exp_ext[0]));
      drive(mk_frame(8'h42, 24'h123456, 1'b0), FB, 128'h0, 0);
      repeat (4) @(negedge pclk);
      exp_ext[0] = 32'h42123456;
      chk("timeout_recover_valid", 64'(ev_cnt[0] - ev0[0]), 64'h1);
      chk("timeout_recover_data", 64'(ext_data[31:0]), 64'(exp_ext[0]));

      // Randomized simultaneous traffic on both channels
      for (int it = 0; it < 20; it++) begin
         for (int k = 0; k < N_CH; k++) begin
            ev0[k] = ev_cnt[k];
            er0[k] = er_cnt[k];
            pre    = $urandom_range(0, 2);
            s[k]   = mk_frame(8'($urandom), 24'($urandom), CS && ($urandom_range(0, 3) == 0));
            s[k]   = s[k] << (8 * pre);
            for (int j = 0; j < pre; j++) begin
               s[k][8*j +: 8] = 8'($urandom);
               if (s[k][8*j +: 8] == 8'hA5) s[k][8*j +: 8] = 8'h5A;
            end
            n[k] = pre + FB;
            rx_model(s[k], n[k], upd[k], err[k], d);
            if (upd[k]) exp_ext[k] = d;
         end
         drive(s[0], n[0], s[1], n[1]);
         repeat (4) @(negedge pclk);
         check_rx_all(ev0, er0, upd, err, "rx_rand");
      end

      // Reset during TX activity and with frames in flight on both RX channels
      cnt = 0;
      while (tx_busy == '0 && cnt < 500) begin
         @(negedge pclk);
         cnt++;
      end
      if (tx_busy == '0) fail_timeout("rst_mid_wait_busy");
      for (int k = 0; k < N_CH; k++) ev0[k] = ev_cnt[k];
      s[0] = mk_frame(8'h11, 24'h223344, 1'b0);
      s[1] = 128'h0201A5;
      for (int t = 0; t < FB; t++) begin
         rx_valid[0]   = 1'b1;
         rx_data[7:0]  = s[0][8*t +: 8];
         rx_valid[1]   = (t >= FB - 3);
         rx_data[15:8] = (t >= FB - 3) ? s[1][8*(t - FB + 3) +: 8] : 8'h00;
         if (t == FB - 1) rst = 1'b0;
         @(negedge pclk);
      end
      rx_valid = '0;
      chk("rst_mid_tx_start", 64'(tx_start), 64'h0);
      chk("rst_mid_tx_data", 64'(tx_data), 64'h0);
      chk("rst_mid_ext_data", 64'(ext_data), 64'h0);
      chk("rst_mid_ext_valid", 64'(ext_valid), 64'h0);
      chk("rst_mid_frame_err", 64'(frame_err), 64'h0);
      @(negedge pclk);
      txlog.delete();
      rst = 1'b1;
      repeat (3) @(negedge pclk);
      chk("rst_mid_no_residual_valid0", 64'(ev_cnt[0] - ev0[0]), 64'h0);
      chk("rst_mid_no_residual_valid1", 64'(ev_cnt[1] - ev0[1]), 64'h0);
      chk("rst_mid_ext_data_after", 64'(ext_data), 64'h0);
      ev0[1] = ev_cnt[1];
      er0[1] = er_cnt[1];
      drive(128'h0, 0, 128'h7766554433, 5);
      repeat (4) @(negedge pclk);
      chk("rst_mid_rx_hunt_valid", 64'(ev_cnt[1] - ev0[1]), 64'h0);
      chk("rst_mid_rx_hunt_err", 64'(er_cnt[1] - er0[1]), 64'h0);
      check_round(local_id, points, "tx_after_reset");
      chk("no_start_while_busy_end", 64'(start_viol), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
